// File: rtl/if_stage_pkg.sv
// Shared definitions for the instruction-fetch stage and its pipeline register.
package if_stage_pkg;

    localparam int          XLEN_DEFAULT = 32;
    localparam logic [31:0] NOP_INSTR    = 32'h0000_0013;

    // Fetch FSM: issue a request, wait for its reply, or hold a reply
    // that decode could not take yet.
    typedef enum logic [1:0] {
        S_REQ  = 2'd0,
        S_WAIT = 2'd1,
        S_HOLD = 2'd2
    } if_state_t;

endpackage

// File: rtl/if_stage_if_id_reg.sv
// Pipeline register carrying {pc, instr, valid}. A write either loads a real
// instruction or inserts a bubble (NOP, valid=0, pc kept for debug).
module if_id_reg
    import if_stage_pkg::*;
#(
    parameter int XLEN = XLEN_DEFAULT
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            write_en,
    input  logic            bubble,
    input  logic [XLEN-1:0] load_pc,
    input  logic [31:0]     load_instr,
    output logic [XLEN-1:0] pc,
    output logic [31:0]     instr,
    output logic            valid
);

    // Load, bubble or hold the stage contents on each clock.
    always_ff @(posedge clk) begin
        if (rst) begin
            pc    <= '0;
            instr <= NOP_INSTR;
            valid <= 1'b0;
        end else if (write_en) begin
            if (bubble) begin
                instr <= NOP_INSTR;
                valid <= 1'b0;
            end else begin
                pc    <= load_pc;
                instr <= load_instr;
                valid <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/if_stage.sv
// Instruction-fetch stage: owns the PC, a one-outstanding fetch FSM, a
// one-entry skid buffer and the IF/ID register.
module if_stage
    import if_stage_pkg::*;
#(
    parameter int              XLEN     = XLEN_DEFAULT,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            PCwrite,
    input  logic            IF_IDwrite,
    input  logic            flush,
    input  logic [XLEN-1:0] branch_target,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_ready,
    input  logic            imem_rvalid,
    input  logic [31:0]     imem_rdata,
    output logic [XLEN-1:0] if_id_pc,
    output logic [31:0]     if_id_instr,
    output logic            if_id_valid,
    output logic            fetch_busy
);

    if_state_t       state, state_next;
    logic [XLEN-1:0] pc, pc_next;
    logic [XLEN-1:0] inflight_pc;
    logic [XLEN-1:0] skid_pc;
    logic [31:0]     skid_instr;
    logic            drop, drop_next;
    logic            inflight_load;
    logic            skid_load;
    logic            deliver;
    logic [XLEN-1:0] deliver_pc;
    logic [31:0]     deliver_instr;
    logic [XLEN-1:0] target_aligned;

    assign target_aligned = branch_target & ~XLEN'(3);

    // A set drop flag in S_REQ means a reply from before reset is still owed
    // by memory; no new request goes out until it has been absorbed, so it
    // can never be mistaken for the reply to a newer request.
    assign imem_req   = (state == S_REQ) & PCwrite & ~flush & ~drop & ~rst;
    assign imem_addr  = pc;
    assign fetch_busy = (state != S_REQ);

    // Next-state logic: flush redirects first, then the fetch handshake.
    always_comb begin
        state_next    = state;
        pc_next       = pc;
        drop_next     = drop;
        inflight_load = 1'b0;
        skid_load     = 1'b0;
        deliver       = 1'b0;
        deliver_pc    = inflight_pc;
        deliver_instr = imem_rdata;
        case (state)
            S_REQ: begin
                if (drop && imem_rvalid) begin
                    drop_next = 1'b0;
                end
                if (flush) begin
                    pc_next = target_aligned;
                end else if (imem_req && imem_ready) begin
                    pc_next       = pc + XLEN'(4);
                    inflight_load = 1'b1;
                    state_next    = S_WAIT;
                end
            end
            S_WAIT: begin
                if (flush) begin
                    pc_next = target_aligned;
                    if (imem_rvalid) begin
                        drop_next  = 1'b0;
                        state_next = S_REQ;
                    end else begin
                        drop_next = 1'b1;
                    end
                end else if (imem_rvalid) begin
                    if (drop) begin
                        drop_next  = 1'b0;
                        state_next = S_REQ;
                    end else if (IF_IDwrite) begin
                        deliver    = 1'b1;
                        state_next = S_REQ;
                    end else begin
                        skid_load  = 1'b1;
                        state_next = S_HOLD;
                    end
                end
            end
            S_HOLD: begin
                if (flush) begin
                    pc_next    = target_aligned;
                    state_next = S_REQ;
                end else if (IF_IDwrite) begin
                    deliver       = 1'b1;
                    deliver_pc    = skid_pc;
                    deliver_instr = skid_instr;
                    state_next    = S_REQ;
                end
            end
            default: begin
                state_next = S_REQ;
            end
        endcase
    end

    // State, PC, drop flag and buffers; reset remembers an unanswered request.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= S_REQ;
            pc          <= RESET_PC;
            drop        <= ((state == S_WAIT) || drop) && !imem_rvalid;
            inflight_pc <= '0;
            skid_pc     <= '0;
            skid_instr  <= NOP_INSTR;
        end else begin
            state <= state_next;
            pc    <= pc_next;
            drop  <= drop_next;
            if (inflight_load) begin
                inflight_pc <= pc;
            end
            if (skid_load) begin
                skid_pc    <= inflight_pc;
                skid_instr <= imem_rdata;
            end
        end
    end

    if_id_reg #(
        .XLEN(XLEN)
    ) u_if_id_reg (
        .clk        (clk),
        .rst        (rst),
        .write_en   (IF_IDwrite | flush),
        .bubble     (~deliver),
        .load_pc    (deliver_pc),
        .load_instr (deliver_instr),
        .pc         (if_id_pc),
        .instr      (if_id_instr),
        .valid      (if_id_valid)
    );

endmodule
